telemetry_tx: RTL and testbench

- Periodic telemetry transmitter driving the eBike's TX pin.
- Consumes the raw 12-bit A2D results (batt, curr, torque) and snapshots them at a fixed rate.
- Serialises each snapshot as a 9-byte framed packet over 8N1 UART so bench tools can log pack and rider state.
- Sits downstream of A2D_intf; instantiated at the eBike top level alongside sensorCondition.

---
 rtl/telemetry_pkg.sv | 30 +++
 rtl/uart_tx.sv | 67 ++++++
 rtl/telemetry_tx.sv | 118 +++++++++++
 tb/tb_telemetry_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// Shared constants, FSM state type and snapshot layout for the telemetry transmitter.
// Timing constants are chosen from FAST_SIM so simulation and silicon share one source.
package telemetry_pkg;

  localparam logic [7:0] SYNC0     = 8'hAA;
  localparam logic [7:0] SYNC1     = 8'h55;
  localparam int         NUM_BYTES = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } tlm_state_t;

  typedef struct packed {
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
  } snap_t;

  function automatic int baud_div(input bit fast_sim);
    return fast_sim ? 16 : 2604;
  endfunction

  function automatic int per_w(input bit fast_sim);
    return fast_sim ? 12 : 20;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit from the clock after trmt, LSB first, BAUD_DIV clocks per bit.
// trmt is ignored while a frame is in flight; tx_done pulses on the last clock of the stop bit.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic {
    UART_IDLE,
    UART_TX
  } uart_state_t;

  uart_state_t   state;
  logic [9:0]    shreg;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_done  = (state == UART_TX) && baud_end && (bit_cnt == 4'd9);
  // Line is forced high whenever idle, so an async reset drops back to mark at once.
  assign TX       = (state == UART_TX) ? shreg[0] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        UART_IDLE: begin
          if (trmt) begin
            shreg    <= {1'b1, tx_data, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= UART_TX;
          end
        end
        UART_TX: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b1, shreg[9:1]};
            if (bit_cnt == 4'd9) begin
              state <= UART_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/telemetry_tx.sv
// Periodic 9-byte telemetry packet (sync, batt, curr, torque, checksum) over 8N1 UART.
// TX falls 3 clocks after the period terminal count; a terminal count mid-packet is dropped.
import telemetry_pkg::*;

module telemetry_tx #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        pkt_sent
);

  localparam int         BAUD_DIV = baud_div(FAST_SIM);
  localparam int         PER_W    = per_w(FAST_SIM);
  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  logic [PER_W-1:0] per_cnt;
  logic             tc;
  tlm_state_t       state;
  snap_t            snap;
  logic [3:0]       idx;
  logic             trmt;
  logic [7:0]       tx_byte;
  logic [7:0]       cur_byte;
  logic [7:0]       chk_sum;
  logic [7:0]       chk_q;
  logic             tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  assign tc = &per_cnt;

  // 8-bit wrapping sum of the six payload bytes, inverted.
  assign chk_sum = ~({4'h0, snap.batt[11:8]}   + snap.batt[7:0] +
                     {4'h0, snap.curr[11:8]}   + snap.curr[7:0] +
                     {4'h0, snap.torque[11:8]} + snap.torque[7:0]);

  always_comb begin
    cur_byte = SYNC0;
    case (idx)
      4'd0:    cur_byte = SYNC0;
      4'd1:    cur_byte = SYNC1;
      4'd2:    cur_byte = {4'h0, snap.batt[11:8]};
      4'd3:    cur_byte = snap.batt[7:0];
      4'd4:    cur_byte = {4'h0, snap.curr[11:8]};
      4'd5:    cur_byte = snap.curr[7:0];
      4'd6:    cur_byte = {4'h0, snap.torque[11:8]};
      4'd7:    cur_byte = snap.torque[7:0];
      4'd8:    cur_byte = chk_q;
      default: cur_byte = SYNC0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      snap     <= '0;
      idx      <= '0;
      trmt     <= 1'b0;
      tx_byte  <= '0;
      chk_q    <= '0;
      pkt_sent <= 1'b0;
    end else begin
      trmt     <= 1'b0;
      pkt_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (tc) begin
            snap  <= '{batt: batt, curr: curr, torque: torque};
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          // Checksum is latched on every load; the snapshot is stable, so byte 8 sees the final value.
          trmt    <= 1'b1;
          tx_byte <= cur_byte;
          chk_q   <= chk_sum;
          state   <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (idx == LAST_IDX) begin
              pkt_sent <= 1'b1;
              state    <= IDLE;
            end else begin
              idx   <= idx + 4'd1;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(tx_byte),
    .TX     (TX),
    .tx_done(tx_done)
  );

endmodule

// File: tb/tb_telemetry_tx.sv
// Scoreboard bench for telemetry_tx (FAST_SIM=1): a UART monitor decodes TX bytes and
// pops hand-computed expected bytes/start cycles; a second monitor checks pkt_sent timing.
module tb_telemetry_tx;

  localparam int BIT_T  = 16;
  localparam int BYTE_T = 10 * BIT_T + 2;
  localparam int PKT_T  = 9 * BYTE_T - 2;
  localparam int PERIOD = 4096;
  localparam int FIRST  = PERIOD + 2;

  typedef struct {
    logic [7:0] dat;
    int         start;
  } exp_byte_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt = '0;
  logic [11:0] curr = '0;
  logic [11:0] torque = '0;
  logic        tx;
  logic        pkt_sent;

  int        cyc;
  int        n_cmp = 0;
  int        n_bad = 0;
  exp_byte_t exp_q[$];
  int        exp_pkt_q[$];

  telemetry_tx #(
    .FAST_SIM(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .batt    (batt),
    .curr    (curr),
    .torque  (torque),
    .TX      (tx),
    .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  // cyc == number of rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic push_packet(input logic [71:0] bytes, input int start, input int nbytes, input bit pkt);
    exp_byte_t e;
    for (int k = 0; k < nbytes; k++) begin
      e.dat   = bytes[71 - 8*k -: 8];
      e.start = start + k * BYTE_T;
      exp_q.push_back(e);
    end
    if (pkt) exp_pkt_q.push_back(start + PKT_T);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic idle_check();
    int bad;
    bad = 0;
    for (int k = 1; k < FIRST; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || pkt_sent !== 1'b0) bad++;
    end
    check("idle_before_first_pkt", 64'(bad), 64'd0);
  endtask

  // UART byte monitor: sample mid-bit, abandon the frame if reset hits.
  initial begin : byte_mon
    int        st;
    logic [7:0] d;
    logic      sb;
    logic      pb;
    bit        ok;
    exp_byte_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        st = cyc;
        d  = '0;
        sb = 1'b1;
        pb = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 9 * BIT_T + BIT_T / 2; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          if (k % BIT_T == BIT_T / 2) begin
            if (k / BIT_T == 0)      sb = tx;
            else if (k / BIT_T == 9) pb = tx;
            else                     d[k / BIT_T - 1] = tx;
          end
        end
        if (ok) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h at cycle %0d, expected none", d, st);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", 64'(d), 64'(e.dat));
            check("byte_start_cycle", 64'(st), 64'(e.start));
            check("byte_framing", 64'({sb, pb}), 64'd1);
          end
        end
      end
    end
  end

  initial begin : pkt_mon
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && pkt_sent === 1'b1) begin
        if (exp_pkt_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pkt_sent: got pulse at cycle %0d, expected none", cyc);
        end else begin
          check("pkt_sent_cycle", 64'(cyc), 64'(exp_pkt_q.pop_front()));
        end
      end
    end
  end

  initial begin : stim
    batt   = 12'hABC;
    curr   = 12'h123;
    torque = 12'h7FF;
    repeat (3) @(negedge clk);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_pkt_sent", 64'(pkt_sent), 64'd0);

    push_packet(72'hAA55_0ABC_0123_07FF_0F, FIRST, 9, 1'b1);
    rst_n = 1'b1;
    idle_check();

    // Second packet snapshots at 8192; batt is cleared just after that edge.
    push_packet(72'hAA55_0ABC_0123_07FF_0F, FIRST + PERIOD, 9, 1'b1);
    wait_cyc(2 * PERIOD);
    batt = 12'h000;
    push_packet(72'hAA55_0000_0123_07FF_D5, FIRST + 2 * PERIOD, 9, 1'b1);

    wait_cyc(3 * PERIOD);
    batt   = 12'hFFF;
    curr   = 12'hFFF;
    torque = 12'hFFF;
    push_packet(72'hAA55_0FFF_0FFF_0FFF_D5, FIRST + 3 * PERIOD, 9, 1'b1);

    wait_cyc(4 * PERIOD);
    batt   = 12'h5A5;
    curr   = 12'h0F0;
    torque = 12'h001;
    push_packet(72'hAA55_05A5_00F0_0001_64, FIRST + 4 * PERIOD, 4, 1'b0);

    // Abort halfway through byte 4.
    wait_cyc(FIRST + 4 * PERIOD + 4 * BYTE_T + 5 * BIT_T);
    rst_n = 1'b0;
    #1;
    check("abort_tx_high", 64'(tx), 64'd1);
    check("abort_pkt_sent", 64'(pkt_sent), 64'd0);
    repeat (3) @(negedge clk);

    push_packet(72'hAA55_05A5_00F0_0001_64, FIRST, 9, 1'b1);
    rst_n = 1'b1;
    idle_check();
    wait_cyc(FIRST + PKT_T + 20);

    check("bytes_outstanding", 64'(exp_q.size()), 64'd0);
    check("pkts_outstanding", 64'(exp_pkt_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
